// File: rtl/pmem_line_responder.sv
// Synthesizable line-granular physical memory: accepts one 256-bit line read or write at a time
// and answers with a single-cycle pmem_resp a fixed number of cycles after acceptance.
module pmem_line_responder #(
    parameter int unsigned ADDR_BITS     = 16,
    parameter int unsigned OFFSET_BITS   = 5,
    parameter int unsigned INDEX_BITS    = 8,
    parameter int unsigned LINE_BITS     = 256,
    parameter int unsigned READ_LATENCY  = 8,
    parameter int unsigned WRITE_LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [ADDR_BITS-1:0] pmem_address,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 pmem_resp,
    output logic                 busy,
    output logic                 pmem_error
);

    localparam int unsigned MAX_LATENCY = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_BITS    = (MAX_LATENCY > 2) ? $clog2(MAX_LATENCY) : 1;
    localparam int unsigned DEPTH       = 32'd1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic                    op_write_q, op_write_d;
    logic [INDEX_BITS-1:0]   index_q, index_d;
    logic [LINE_BITS-1:0]    wdata_q;
    logic                    accept;
    logic [31:0]             req_latency;
    logic [LINE_BITS-1:0]    mem [DEPTH];

    // Offset bits and bits above the index are don't-care (lines alias across the address space)
    logic unused_addr;
    assign unused_addr = ^pmem_address;

    // A simultaneous read+write is handled as a write, so it takes the write latency
    assign req_latency = pmem_write ? WRITE_LATENCY : READ_LATENCY;

    // Next-state logic; request inputs only matter in IDLE
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        op_write_d = op_write_q;
        index_d    = index_q;
        case (state_q)
            S_IDLE: begin
                if (pmem_read || pmem_write) begin
                    accept     = 1'b1;
                    op_write_d = pmem_write;
                    index_d    = pmem_address[OFFSET_BITS +: INDEX_BITS];
                    if (req_latency <= 32'd1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_BITS'(req_latency - 32'd1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_BITS'(1);
                if (cnt_q == CNT_BITS'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; resp/busy are decoded from the next state so they stay registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            index_q    <= '0;
            pmem_resp  <= 1'b0;
            busy       <= 1'b0;
            pmem_error <= 1'b0;
            pmem_rdata <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            index_q    <= index_d;
            pmem_resp  <= (state_d == S_RESP);
            busy       <= (state_d != S_IDLE);
            if (accept && pmem_read && pmem_write) begin
                pmem_error <= 1'b1;
            end
            if ((state_d == S_RESP) && !op_write_d) begin
                pmem_rdata <= mem[index_d];
            end
        end
    end

    // Line store; a write commits only at its RESP edge, so a reset mid-transaction drops it
    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q <= pmem_wdata;
        end
        if ((state_q == S_RESP) && op_write_q) begin
            mem[index_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder: directed scenarios plus randomized traffic
// checked against a line-array reference model.
module tb_pmem_line_responder;

    localparam int unsigned RL  = 8;
    localparam int unsigned WL  = 8;
    localparam int unsigned RL2 = 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pmem_read = 1'b0, pmem_write = 1'b0;
    logic [15:0]  pmem_address = '0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp, busy, pmem_error;

    logic         r2 = 1'b0, w2 = 1'b0;
    logic [15:0]  a2 = '0;
    logic [255:0] wd2 = '0;
    logic [255:0] rdata2;
    logic         resp2, busy2, err2;

    int tests_run = 0;
    int tests_failed = 0;

    logic [255:0] model [256];
    logic [255:0] last_rdata;

    always #5 clk = ~clk;

    pmem_line_responder #(.READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
        .clk(clk), .reset(reset), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .busy(busy), .pmem_error(pmem_error)
    );

    pmem_line_responder #(.READ_LATENCY(RL2), .WRITE_LATENCY(WL)) dut_fast (
        .clk(clk), .reset(reset), .pmem_read(r2), .pmem_write(w2),
        .pmem_address(a2), .pmem_wdata(wd2), .pmem_rdata(rdata2),
        .pmem_resp(resp2), .busy(busy2), .pmem_error(err2)
    );

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [39:0] busy_window(input int lat);
        return 40'((64'd1 << lat) - 64'd1);
    endfunction

    // Drives one transaction and records what the DUT did; k counts edges from acceptance
    task automatic drive_txn(input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [255:0] data, input int drop_at,
                             output int resp_at, output int resp_cnt,
                             output logic [255:0] rd_seen, output logic [39:0] busy_trace);
        resp_at = 0; resp_cnt = 0; rd_seen = '0; busy_trace = '0;
        pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = data;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            busy_trace[k-1] = busy;
            if (pmem_resp) begin
                resp_cnt++;
                if (resp_at == 0) begin
                    resp_at = k;
                    rd_seen = pmem_rdata;
                end
            end
            if (k == drop_at || pmem_resp) begin
                pmem_read = 1'b0; pmem_write = 1'b0;
            end
            if (resp_at != 0 && k >= resp_at + 2) break;
        end
        pmem_read = 1'b0; pmem_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({pmem_resp, busy, pmem_error, resp2, busy2, err2} !== 6'b0 || pmem_rdata !== '0 || rdata2 !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: resp=%b busy=%b err=%b rdata_nonzero=%b, required all 0",
                     pmem_resp, busy, pmem_error, |pmem_rdata);
        end
        reset = 1'b0;
        last_rdata = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int ra, rc; logic [255:0] rs; logic [39:0] bt;
        logic [255:0] line_a5 = {32{8'hA5}};
        drive_txn(1'b0, 1'b1, 16'h0040, line_a5, 0, ra, rc, rs, bt);
        model[8'h02] = line_a5;
        tests_run++;
        if (ra != WL || rc != 1 || bt !== busy_window(WL)) begin
            tests_failed++;
            $display("FAIL write_latency: resp_at=%0d pulses=%0d busy=%h, required %0d 1 %h", ra, rc, bt, WL, busy_window(WL));
        end
        tests_run++;
        if (rs !== last_rdata) begin
            tests_failed++;
            $display("FAIL write_keeps_rdata: rdata=%h, required %h", rs, last_rdata);
        end
        drive_txn(1'b1, 1'b0, 16'h0040, '0, 0, ra, rc, rs, bt);
        last_rdata = model[8'h02];
        tests_run++;
        if (ra != RL || rc != 1 || bt !== busy_window(RL) || rs !== line_a5) begin
            tests_failed++;
            $display("FAIL read_after_write: resp_at=%0d pulses=%0d rdata=%h, required %0d 1 %h", ra, rc, rs, RL, line_a5);
        end
    endtask

    task automatic test_back_to_back();
        int r1 = 0, r2c = 0;
        logic exp_busy;
        logic [255:0] d1 = '0, d2 = '0;
        pmem_read = 1'b1; pmem_address = 16'h0040;
        for (int k = 1; k <= 2*RL + 2; k++) begin
            @(posedge clk); #1;
            exp_busy = (k <= RL) || (k >= RL + 2 && k <= 2*RL + 1);
            tests_run++;
            if (busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL b2b_busy: cycle %0d busy=%b, required %b", k, busy, exp_busy);
            end
            if (pmem_resp) begin
                if (r1 == 0) begin r1 = k; d1 = pmem_rdata; end
                else if (r2c == 0) begin r2c = k; d2 = pmem_rdata; end
            end
            if (k == 2*RL + 1) pmem_read = 1'b0;
        end
        tests_run++;
        if (r1 != RL || r2c != 2*RL + 1 || d1 !== model[8'h02] || d2 !== model[8'h02]) begin
            tests_failed++;
            $display("FAIL b2b_timing: resp at %0d and %0d, required %0d and %0d", r1, r2c, RL, 2*RL + 1);
        end
    endtask

    task automatic test_alias();
        int ra, rc; logic [255:0] rs; logic [39:0] bt;
        drive_txn(1'b0, 1'b1, 16'h0000, {64{4'h1}}, 0, ra, rc, rs, bt);
        drive_txn(1'b0, 1'b1, 16'h2000, {64{4'h2}}, 0, ra, rc, rs, bt);
        model[8'h00] = {64{4'h2}};
        drive_txn(1'b1, 1'b0, 16'h0000, '0, 0, ra, rc, rs, bt);
        last_rdata = model[8'h00];
        tests_run++;
        if (rs !== {64{4'h2}} || ra != RL) begin
            tests_failed++;
            $display("FAIL alias_read: rdata=%h resp_at=%0d, required %h %0d", rs, ra, {64{4'h2}}, RL);
        end
    endtask

    task automatic test_random();
        int ra, rc; logic [255:0] rs, d; logic [39:0] bt;
        logic [15:0] addr; bit wr; int lat;
        logic [15:0] written [$];
        for (int i = 0; i < 40; i++) begin
            wr = (written.size() == 0) || ($urandom_range(0, 1) == 1);
            if (wr) addr = 16'($urandom);
            else begin
                addr = written[$urandom_range(0, written.size() - 1)];
                addr[15:13] = 3'($urandom);
            end
            d = rand_line();
            lat = wr ? WL : RL;
            drive_txn(~wr, wr, addr, d, $urandom_range(1, 9), ra, rc, rs, bt);
            if (wr) begin
                model[addr[12:5]] = d;
                written.push_back(addr);
            end else begin
                last_rdata = model[addr[12:5]];
            end
            tests_run++;
            if (ra != lat || rc != 1 || bt !== busy_window(lat) || rs !== last_rdata) begin
                tests_failed++;
                $display("FAIL random_txn %0d: wr=%b addr=%h resp_at=%0d pulses=%0d busy=%h rdata=%h, required %0d 1 %h %h",
                         i, wr, addr, ra, rc, bt, rs, lat, busy_window(lat), last_rdata);
            end
        end
        tests_run++;
        if (pmem_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_error: pmem_error=%b, required 0", pmem_error);
        end
    endtask

    task automatic test_drop_mid();
        int ra, rc; logic [255:0] rs; logic [39:0] bt;
        drive_txn(1'b1, 1'b0, 16'h0040, '0, 3, ra, rc, rs, bt);
        last_rdata = model[8'h02];
        tests_run++;
        if (ra != RL || rc != 1 || bt !== busy_window(RL) || rs !== last_rdata) begin
            tests_failed++;
            $display("FAIL drop_mid: resp_at=%0d pulses=%0d busy=%h, required %0d 1 %h", ra, rc, bt, RL, busy_window(RL));
        end
    endtask

    task automatic test_both_high();
        int ra, rc; logic [255:0] rs; logic [39:0] bt;
        logic [255:0] d = {16{16'h1234}};
        drive_txn(1'b1, 1'b1, 16'h0100, d, 0, ra, rc, rs, bt);
        model[8'h08] = d;
        tests_run++;
        if (ra != WL || pmem_error !== 1'b1 || rs !== last_rdata) begin
            tests_failed++;
            $display("FAIL both_high: resp_at=%0d err=%b, required %0d 1", ra, pmem_error, WL);
        end
        drive_txn(1'b1, 1'b0, 16'h0100, '0, 0, ra, rc, rs, bt);
        last_rdata = d;
        tests_run++;
        if (rs !== d || pmem_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL both_high_readback: rdata=%h err=%b, required %h 1", rs, pmem_error, d);
        end
    endtask

    task automatic test_reset_mid_wait();
        int ra, rc; logic [255:0] rs; logic [39:0] bt;
        logic [255:0] prior = rand_line();
        drive_txn(1'b0, 1'b1, 16'h0080, prior, 0, ra, rc, rs, bt);
        model[8'h04] = prior;
        pmem_write = 1'b1; pmem_address = 16'h0080; pmem_wdata = {256{1'b1}};
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({pmem_resp, busy, pmem_error} !== 3'b0 || pmem_rdata !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: resp=%b busy=%b err=%b rdata_nonzero=%b, required all 0",
                     pmem_resp, busy, pmem_error, |pmem_rdata);
        end
        pmem_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        last_rdata = '0;
        @(posedge clk); #1;
        drive_txn(1'b1, 1'b0, 16'h0080, '0, 0, ra, rc, rs, bt);
        last_rdata = model[8'h04];
        tests_run++;
        if (rs !== prior || ra != RL) begin
            tests_failed++;
            $display("FAIL reset_drops_write: rdata=%h resp_at=%0d, required %h %0d", rs, ra, prior, RL);
        end
    endtask

    task automatic test_latency_one();
        int wat = 0;
        logic [255:0] y = rand_line();
        w2 = 1'b1; a2 = 16'h0040; wd2 = y;
        for (int k = 1; k <= WL + 2; k++) begin
            @(posedge clk); #1;
            if (resp2 && wat == 0) begin wat = k; w2 = 1'b0; end
        end
        w2 = 1'b0;
        tests_run++;
        if (wat != WL) begin
            tests_failed++;
            $display("FAIL fast_write_latency: resp_at=%0d, required %0d", wat, WL);
        end
        r2 = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (resp2 !== 1'b1 || busy2 !== 1'b1 || rdata2 !== y) begin
            tests_failed++;
            $display("FAIL fast_read_resp: resp=%b busy=%b rdata=%h, required 1 1 %h", resp2, busy2, rdata2, y);
        end
        r2 = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (resp2 !== 1'b0 || busy2 !== 1'b0 || rdata2 !== y) begin
            tests_failed++;
            $display("FAIL fast_read_done: resp=%b busy=%b rdata=%h, required 0 0 %h", resp2, busy2, rdata2, y);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_alias();
        test_random();
        test_drop_mid();
        test_both_high();
        test_reset_mid_wait();
        test_latency_one();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
